sr_button_ctrl: RTL and testbench
=================================

# sr_button_ctrl

Front-end stage that turns two raw pushbuttons (set, reset) into clean, mutually exclusive single-cycle S and R command pulses for the downstream SR flip-flop. Each button is synchronised, debounced and edge-detected. A small arbitration FSM suppresses pulses while both buttons are held and flags the condition. This keeps the invalid S=R=1 combination from ever reaching the flip-flop.

## Interface
Parameters:
- DB_CYCLES, default 4 — consecutive cycles a synchronised input must differ from its debounced level before the level flips; legal range ≥1.
- CNT_W, default 8 — width of press_cnt.

Ports:
- clk  input  1  single system clock, all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- btn_set  input  1  raw set button, asynchronous to clk.
- btn_rst  input  1  raw reset button, asynchronous to clk.
- S  output  1  registered one-cycle set pulse to SR flip-flop.
- R  output  1  registered one-cycle reset pulse to SR flip-flop.
- conflict  output  1  registered; high while FSM is in CONFLICT.
- press_cnt  output  CNT_W  count of emitted S plus R pulses; wraps modulo 2^CNT_W.

## Operation
- Synchroniser: two flip-flops per button; set_sync and rst_sync are the second-stage outputs.
- Debounce, per channel: keeps a debounced level (db) and a counter sized by $clog2(DB_CYCLES+1).
  - sync == db: counter cleared.
  - sync != db: counter increments.
  - When the increment would reach DB_CYCLES: db <= sync and counter cleared.
  - Any glitch shorter than DB_CYCLES cycles leaves db unchanged.
- FSM states are IDLE, SET_HELD, RST_HELD, CONFLICT. Inputs are set_db and rst_db.
  - IDLE:
    - set only → SET_HELD, S pulse.
    - rst only → RST_HELD, R pulse.
    - both → CONFLICT, no pulse.
    - neither → stay.
  - SET_HELD:
    - set=1, rst=1 → CONFLICT.
    - set=0, rst=1 → RST_HELD, R pulse.
    - set=0, rst=0 → IDLE.
    - otherwise stay.
  - RST_HELD: mirror of SET_HELD, with S pulse on set-only.
  - CONFLICT:
    - both → stay.
    - exactly one held → that HELD state, no pulse; the button must be released and re-pressed to emit.
    - neither → IDLE.
- S and R are never high in the same cycle. Each pulse lasts exactly one cycle per qualifying transition.
- press_cnt increments by 1 in the cycle S or R is registered high. It wraps from 2^CNT_W−1 to 0.
- Reset (reset_n=0): S=0, R=0, conflict=0, press_cnt=0, sync and db registers 0, debounce counters 0, state IDLE. All take effect immediately, without waiting for clk.
- Reset deasserted while a button is held: the held button is treated as a new press and emits a pulse after normal debounce latency.

## Timing
- Input stable from before rising edge E0 (first sampling edge):
  - set_sync = 1 after E0+1.
  - db flips at E0+1+DB_CYCLES.
  - S (or R) is high for the single cycle following edge E0+DB_CYCLES+2.
  - With DB_CYCLES=4, S rises after E0+6.
- conflict rises on the same edge the FSM enters CONFLICT. It falls on the edge the FSM leaves.
- press_cnt updates on the same edge S/R is asserted. It is visible in the pulse cycle.
- Release latency equals press latency: DB_CYCLES+2 edges to the FSM state change.
- Simultaneous db flips of both channels on one edge are handled by the both/neither arcs above. No ordering priority applies.
- Reset asserted mid-debounce aborts the pending flip. No pulse is emitted for that press until re-debounced after reset release.

## Test plan
- Clean set press, DB_CYCLES=4: btn_set 0→1 before E0, held 20 cycles → S high exactly one cycle after E0+6, R=0, press_cnt=1, conflict=0.
- Bounce rejection: btn_set pulses high for 3 cycles, then 0 → S, R stay 0, press_cnt=0. Same test with a 4-cycle pulse → exactly one S pulse.
- Simultaneous press: btn_set and btn_rst rise on the same cycle → conflict=1 after E0+6, no S/R. Release btn_rst → conflict=0, still no S. Release btn_set, press btn_set again → one S pulse, press_cnt=1.
- Handover: btn_set held, S emitted. Release btn_set and press btn_rst in the same cycle → one R pulse with no intervening conflict, press_cnt=2.
- Wrap: 256 alternating clean set/reset presses, CNT_W=8 → press_cnt returns to 0. S/R never both high in any cycle.
- Async reset mid-operation: reset_n low between clock edges while SET_HELD with press_cnt=5 → all outputs 0 immediately. Release reset_n with btn_set still held → one S pulse DB_CYCLES+2 edges later, press_cnt=1.

Source files
------------

// File: rtl/sr_button_ctrl.sv
// Two-button front end: synchronise, debounce and edge-qualify set/reset presses
// into mutually exclusive one-cycle S/R pulses, flagging both-held as a conflict.
module sr_button_ctrl #(
    parameter int DB_CYCLES = 4,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             btn_set,
    input  logic             btn_rst,
    output logic             S,
    output logic             R,
    output logic             conflict,
    output logic [CNT_W-1:0] press_cnt
);

    localparam int            CW      = (DB_CYCLES < 1) ? 1 : $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SET_HELD,
        ST_RST_HELD,
        ST_CONFLICT
    } state_t;

    logic [1:0] w_btn;
    logic [1:0] w_sync;
    logic [1:0] w_db;
    logic       w_set_db;
    logic       w_rst_db;

    assign w_btn    = {btn_rst, btn_set};
    assign w_set_db = w_db[0];
    assign w_rst_db = w_db[1];

    // Channel 0 is set, channel 1 is reset.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chan
            logic          r_sync1;
            logic          r_sync2;
            logic          r_db;
            logic [CW-1:0] r_cnt;
            logic [CW-1:0] w_cnt_inc;

            assign w_cnt_inc = r_cnt + CW'(1);
            assign w_sync[gi] = r_sync2;
            assign w_db[gi]   = r_db;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_sync1 <= 1'b0;
                    r_sync2 <= 1'b0;
                    r_db    <= 1'b0;
                    r_cnt   <= '0;
                end else begin
                    r_sync1 <= w_btn[gi];
                    r_sync2 <= r_sync1;
                    if (r_sync2 == r_db) begin
                        r_cnt <= '0;
                    end else if (w_cnt_inc == DB_LAST) begin
                        r_db  <= r_sync2;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
            end
        end
    endgenerate

    state_t           r_state;
    state_t           w_state_next;
    logic             w_s_next;
    logic             w_r_next;
    logic             r_s;
    logic             r_r;
    logic             r_conflict;
    logic [CNT_W-1:0] r_press_cnt;

    // Leaving CONFLICT never pulses: a held button must be released and pressed again.
    always_comb begin
        w_state_next = r_state;
        w_s_next     = 1'b0;
        w_r_next     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                case ({w_set_db, w_rst_db})
                    2'b10:   begin w_state_next = ST_SET_HELD; w_s_next = 1'b1; end
                    2'b01:   begin w_state_next = ST_RST_HELD; w_r_next = 1'b1; end
                    2'b11:   w_state_next = ST_CONFLICT;
                    default: w_state_next = ST_IDLE;
                endcase
            end
            ST_SET_HELD: begin
                case ({w_set_db, w_rst_db})
                    2'b11:   w_state_next = ST_CONFLICT;
                    2'b01:   begin w_state_next = ST_RST_HELD; w_r_next = 1'b1; end
                    2'b00:   w_state_next = ST_IDLE;
                    default: w_state_next = ST_SET_HELD;
                endcase
            end
            ST_RST_HELD: begin
                case ({w_set_db, w_rst_db})
                    2'b11:   w_state_next = ST_CONFLICT;
                    2'b10:   begin w_state_next = ST_SET_HELD; w_s_next = 1'b1; end
                    2'b00:   w_state_next = ST_IDLE;
                    default: w_state_next = ST_RST_HELD;
                endcase
            end
            default: begin
                case ({w_set_db, w_rst_db})
                    2'b10:   w_state_next = ST_SET_HELD;
                    2'b01:   w_state_next = ST_RST_HELD;
                    2'b00:   w_state_next = ST_IDLE;
                    default: w_state_next = ST_CONFLICT;
                endcase
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_s         <= 1'b0;
            r_r         <= 1'b0;
            r_conflict  <= 1'b0;
            r_press_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_s        <= w_s_next;
            r_r        <= w_r_next;
            r_conflict <= (w_state_next == ST_CONFLICT);
            if (w_s_next || w_r_next) begin
                r_press_cnt <= r_press_cnt + CNT_W'(1);
            end
        end
    end

    assign S         = r_s;
    assign R         = r_r;
    assign conflict  = r_conflict;
    assign press_cnt = r_press_cnt;

endmodule

// File: tb/tb_sr_button_ctrl.sv
// Self-checking bench for sr_button_ctrl: vector table, hand sequences for the
// multi-cycle corners, and random stimulus against a window-based reference model.
module tb_sr_button_ctrl;

    localparam int DB    = 4;
    localparam int CNT_W = 8;

    logic             clk     = 1'b0;
    logic             reset_n = 1'b0;
    logic             btn_set = 1'b0;
    logic             btn_rst = 1'b0;
    logic             S;
    logic             R;
    logic             conflict;
    logic [CNT_W-1:0] press_cnt;

    sr_button_ctrl #(.DB_CYCLES(DB), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .btn_set   (btn_set),
        .btn_rst   (btn_rst),
        .S         (S),
        .R         (R),
        .conflict  (conflict),
        .press_cnt (press_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at time %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a button level is accepted once the last DB synchronised
    // samples all disagree with it; a pulse is a debounced rise while the other
    // button is debounced low, and conflict is simply both debounced high.
    logic [1:0]       m_s1, m_s2, m_db, m_seen;
    logic [DB-1:0]    m_win [2];
    logic             m_S, m_R, m_conf;
    logic [CNT_W-1:0] m_cnt;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_s1 = '0; m_s2 = '0; m_db = '0; m_seen = '0;
            m_win[0] = '0; m_win[1] = '0;
            m_S = 1'b0; m_R = 1'b0; m_conf = 1'b0; m_cnt = '0;
        end else begin
            m_S    = m_db[0] & ~m_db[1] & ~m_seen[0];
            m_R    = m_db[1] & ~m_db[0] & ~m_seen[1];
            m_conf = m_db[0] & m_db[1];
            if (m_S || m_R) m_cnt = m_cnt + 1'b1;
            m_seen = m_db;
            for (int ch = 0; ch < 2; ch++) begin
                m_win[ch] = {m_win[ch][DB-2:0], m_s2[ch]};
                if (m_db[ch] ? (m_win[ch] == '0) : (m_win[ch] == '1)) m_db[ch] = ~m_db[ch];
            end
            m_s2 = m_s1;
            m_s1 = {btn_rst, btn_set};
        end
    end

    int s_total = 0;
    int r_total = 0;
    int conf_cycles = 0;

    always @(posedge clk) begin
        #1;
        if (reset_n) begin
            check("model_S", S, m_S);
            check("model_R", R, m_R);
            check("model_conflict", conflict, m_conf);
            check("model_press_cnt", press_cnt, m_cnt);
            check("S_R_exclusive", S & R, 0);
            if (S) s_total++;
            if (R) r_total++;
            if (conflict) conf_cycles++;
        end
    end

    typedef struct {
        int ss, sl, rs, rl;   // set start/len, reset start/len (cycles)
        int es, er, ec;       // expected S pulses, R pulses, conflict seen
    } vec_t;
    vec_t vecs [11];

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        btn_set = 1'b0;
        btn_rst = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, r0, c0, lens, lenr;
        vecs[0]  = '{0, 3,  0, 0,  0, 0, 0};
        vecs[1]  = '{0, 4,  0, 0,  1, 0, 0};
        vecs[2]  = '{0, 20, 0, 0,  1, 0, 0};
        vecs[3]  = '{0, 0,  0, 20, 0, 1, 0};
        vecs[4]  = '{0, 20, 0, 20, 0, 0, 1};
        vecs[5]  = '{0, 10, 10, 10, 1, 1, 0};
        vecs[6]  = '{0, 10, 20, 10, 1, 1, 0};
        vecs[7]  = '{0, 30, 5, 10, 1, 0, 1};
        vecs[8]  = '{5, 10, 0, 30, 0, 1, 1};
        vecs[9]  = '{0, 20, 8, 3,  1, 0, 0};
        vecs[10] = '{2, 3,  0, 20, 0, 1, 0};

        // Reset state, outputs forced low without a clock edge being needed.
        repeat (3) @(negedge clk);
        check("reset_S", S, 0);
        check("reset_R", R, 0);
        check("reset_conflict", conflict, 0);
        check("reset_press_cnt", press_cnt, 0);
        reset_n = 1'b1;
        cycles(2);

        // Clean press: S high only in the cycle after E0+6.
        @(negedge clk);
        btn_set = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            check("press_S_timing", S, (k == 6));
            check("press_R_low", R, 0);
        end
        check("press_cnt_one", press_cnt, 1);
        cycles(12);
        btn_set = 1'b0;
        cycles(12);
        check("press_cnt_after_release", press_cnt, 1);

        // Vector table.
        foreach (vecs[v]) begin
            s0 = s_total; r0 = r_total; c0 = conf_cycles;
            for (int c = 0; c < 60; c++) begin
                @(negedge clk);
                btn_set = (c >= vecs[v].ss) && (c < vecs[v].ss + vecs[v].sl);
                btn_rst = (c >= vecs[v].rs) && (c < vecs[v].rs + vecs[v].rl);
            end
            cycles(2);
            check($sformatf("vec%0d_S_pulses", v), s_total - s0, vecs[v].es);
            check($sformatf("vec%0d_R_pulses", v), r_total - r0, vecs[v].er);
            check($sformatf("vec%0d_conflict_seen", v), (conf_cycles > c0), vecs[v].ec);
        end

        // Simultaneous press, partial release, re-press.
        do_reset();
        btn_set = 1'b1; btn_rst = 1'b1;
        cycles(10);
        check("simul_conflict_high", conflict, 1);
        check("simul_press_cnt", press_cnt, 0);
        btn_rst = 1'b0;
        cycles(10);
        check("simul_conflict_low", conflict, 0);
        check("simul_no_S", press_cnt, 0);
        btn_set = 1'b0;
        cycles(10);
        btn_set = 1'b1;
        cycles(10);
        check("simul_repress_cnt", press_cnt, 1);
        btn_set = 1'b0;
        cycles(10);

        // Handover: release set and press reset on the same cycle.
        do_reset();
        btn_set = 1'b1;
        cycles(10);
        check("handover_first", press_cnt, 1);
        c0 = conf_cycles;
        btn_set = 1'b0; btn_rst = 1'b1;
        cycles(10);
        check("handover_cnt", press_cnt, 2);
        check("handover_no_conflict", conf_cycles - c0, 0);
        btn_rst = 1'b0;
        cycles(10);

        // Wrap: 256 alternating presses return the counter to zero.
        do_reset();
        s0 = s_total; r0 = r_total;
        for (int i = 0; i < 256; i++) begin
            btn_set = (i % 2 == 0);
            btn_rst = (i % 2 == 1);
            cycles(8);
        end
        btn_set = 1'b0; btn_rst = 1'b0;
        cycles(10);
        check("wrap_press_cnt", press_cnt, 0);
        check("wrap_S_pulses", s_total - s0, 128);
        check("wrap_R_pulses", r_total - r0, 128);

        // Asynchronous reset while SET_HELD with five presses counted.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            btn_set = 1'b1; cycles(8);
            btn_set = 1'b0; cycles(8);
        end
        btn_set = 1'b1;
        cycles(10);
        check("async_pre_cnt", press_cnt, 5);
        #2 reset_n = 1'b0;
        #1;
        check("async_S", S, 0);
        check("async_R", R, 0);
        check("async_conflict", conflict, 0);
        check("async_press_cnt", press_cnt, 0);
        @(negedge clk);
        #2 reset_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            check("async_release_S", S, (k == 6));
        end
        check("async_release_cnt", press_cnt, 1);
        @(negedge clk);
        btn_set = 1'b0;
        cycles(10);

        // Random button activity with bursts of varying length.
        do_reset();
        lens = 0; lenr = 0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (lens == 0) begin
                btn_set = $urandom_range(0, 1);
                lens = $urandom_range(1, 10);
            end
            if (lenr == 0) begin
                btn_rst = $urandom_range(0, 1);
                lenr = $urandom_range(1, 10);
            end
            lens--; lenr--;
        end
        btn_set = 1'b0; btn_rst = 1'b0;
        cycles(12);
        check("random_idle_conflict", conflict, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
